dot_product_row_scheduler: RTL and testbench
============================================

// Module: dot_product_row_scheduler
// PURPOSE
//  Sequences a matrix-vector product through one NI-lane dot-product engine: for each row, fetches CHUNKS
//  packed beats of row data and vector data, zero-pads the tail, paces the beats into the engine and
//  collects one 32-bit float result per row. Sits between the A/x row memories and the dot-product engine;
//  it feeds the engine's read-now/no_of_multiples interface.
// PARAMETERS
//  NOE      10   elements per row (vector length)
//  NI       8    lanes per beat (even, >=2); lane 0 = bits [32*NI-1 -: 32]
//  ADDR_W   12   memory beat-address width
//  BEAT_GAP 2    cycles between beats (engine consumes NI/2 lanes per cycle); must be >=1
//  TIMEOUT  256  watchdog limit in cycles (used only with DPS_TIMEOUT_EN)
//  derived: CHUNKS = ceil(NOE/NI); TAIL = NOE - (CHUNKS-1)*NI (valid lanes in the last beat)
// PORTS
//  clk               in   1        clock, all logic on posedge
//  reset             in   1        synchronous, active-high
//  start             in   1        start pulse; sampled only in IDLE
//  num_rows          in   16       rows to process, latched on accepted start
//  busy              out  1        high from the accepted start until the done pulse, inclusive
//  done              out  1        one-cycle pulse after the last row's result is accepted
//  rd_en             out  1        memory read strobe, fixed 1-cycle read latency
//  rd_addr_a         out  ADDR_W   row*CHUNKS + chunk
//  rd_addr_x         out  ADDR_W   chunk
//  rd_data_a         in   32*NI    A beat, valid the cycle after rd_en
//  rd_data_x         in   32*NI    x beat, valid the cycle after rd_en
//  eng_read_now      out  1        one-cycle pulse with the first beat of each row
//  eng_no_of_mult    out  32       = CHUNKS, stable while busy
//  eng_valid         out  1        beat valid to the engine (= rd_en delayed 1)
//  eng_row_a         out  32*NI    masked rd_data_a
//  eng_row_x         out  32*NI    masked rd_data_x
//  eng_result_valid  in   1        engine result strobe
//  eng_result        in   32       engine dot product
//  res_valid         out  1        result valid to the consumer
//  res_ready         in   1        consumer accept
//  res_row           out  16       row index of res_data
//  res_data          out  32       latched dot product
//  err               out  1        sticky watchdog flag (tied 0 without DPS_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, rd_en, eng_read_now, eng_valid, res_valid and err = 0;
//    addresses, row and chunk counters, res_row and res_data = 0. A mid-operation reset aborts immediately,
//    and any engine result arriving later is ignored.
//  - FSM IDLE->ISSUE->WAIT->WRITE->(ISSUE | DONE)->IDLE.
//  - IDLE: start=1 latches num_rows and sets busy. num_rows=0 goes straight to DONE: no reads are issued.
//  - ISSUE: rd_en is high for one cycle per chunk, chunk 0..CHUNKS-1, with BEAT_GAP cycles between rd_en
//    pulses. After the last rd_en, go to WAIT.
//  - Data path: eng_valid, eng_row_a and eng_row_x follow rd_en by 1 cycle. eng_read_now coincides with
//    eng_valid of chunk 0.
//  - Masking: on the last chunk, lanes TAIL..NI-1 are forced to 32'h0 on both A and x; all other beats
//    pass unmodified.
//  - WAIT: the first eng_result_valid latches eng_result into res_data, sets res_row = current row and
//    goes to WRITE. eng_result_valid in any other state is ignored.
//  - WRITE: res_valid is held, with res_data and res_row stable, until res_valid & res_ready.
//    On that handshake: row+1; if row+1 == num_rows go to DONE, else go to ISSUE.
//  - DONE: done=1 for one cycle, busy drops the next cycle, return to IDLE.
//  - start while busy is ignored. Only one row is in flight at a time.
// CONFIGURATION
//  - DPS_TIMEOUT_EN defined: in WAIT, a cycle counter (cleared on WAIT entry) reaching TIMEOUT sets err
//    (sticky until reset), skips the remaining rows and goes to DONE. No res_valid is issued for the
//    timed-out row.
//  - Not defined: no counter; WAIT waits indefinitely; err is tied 0.
// TESTING
//  1. NOE=10, NI=8, num_rows=3, engine result returns 5 cycles after read_now, res_ready=1
//     -> 6 rd_en pulses, rd_addr_a 0..5, rd_addr_x 0,1,0,1,0,1; res_row 0,1,2; one done pulse.
//  2. Last beat all 32'h3F800000 -> eng_row_a lanes 0-1 = 3F800000, lanes 2-7 = 0; non-last beats unmasked.
//  3. res_ready held low 10 cycles in WRITE -> res_valid, res_data, res_row stable; no rd_en until accepted.
//  4. num_rows=0 -> done the cycle after busy rises; rd_en never asserts.
//  5. reset asserted in WAIT of row 1, then eng_result_valid -> outputs at reset values, res_valid stays 0.
//  6. DPS_TIMEOUT_EN, TIMEOUT=16, engine silent -> err=1 16 cycles after WAIT entry, done pulse, no res_valid.

Source files
------------

// File: rtl/dot_product_row_scheduler.sv
// Row-at-a-time matrix-vector sequencer feeding an NI-lane dot-product engine.
// Optional watchdog: define DPS_TIMEOUT_EN to abort a stalled row after TIMEOUT cycles in WAIT.
module dot_product_row_scheduler #(
    parameter int NOE      = 10,
    parameter int NI       = 8,
    parameter int ADDR_W   = 12,
    parameter int BEAT_GAP = 2,
    parameter int TIMEOUT  = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [15:0]         num_rows,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr_a,
    output logic [ADDR_W-1:0]   rd_addr_x,
    input  logic [32*NI-1:0]    rd_data_a,
    input  logic [32*NI-1:0]    rd_data_x,
    output logic                eng_read_now,
    output logic [31:0]         eng_no_of_mult,
    output logic                eng_valid,
    output logic [32*NI-1:0]    eng_row_a,
    output logic [32*NI-1:0]    eng_row_x,
    input  logic                eng_result_valid,
    input  logic [31:0]         eng_result,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [15:0]         res_row,
    output logic [31:0]         res_data,
    output logic                err
);
    localparam int CHUNKS = (NOE + NI - 1) / NI;
    localparam int TAIL   = NOE - (CHUNKS - 1) * NI;
    localparam int GAP_W  = (BEAT_GAP > 1) ? $clog2(BEAT_GAP) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [15:0]        rows_q;
    logic [15:0]        row;
    logic [15:0]        chunk;
    logic [GAP_W-1:0]   gap;
    logic               last_chunk;
    logic               last_q;
    logic               timeout_hit;

    assign last_chunk     = (chunk == 16'(CHUNKS - 1));
    assign rd_addr_a      = ADDR_W'(32'(row) * CHUNKS + 32'(chunk));
    assign rd_addr_x      = ADDR_W'(chunk);
    assign eng_no_of_mult = 32'(CHUNKS);

    // State register plus the counters and latches that ride along with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            rows_q       <= '0;
            row          <= '0;
            chunk        <= '0;
            gap          <= '0;
            res_row      <= '0;
            res_data     <= '0;
            eng_valid    <= 1'b0;
            eng_read_now <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state        <= state_nxt;
            eng_valid    <= rd_en;
            eng_read_now <= rd_en && (chunk == 16'd0);
            last_q       <= rd_en && last_chunk;
            case (state)
                S_IDLE: if (start) begin
                    rows_q <= num_rows;
                    row    <= '0;
                    chunk  <= '0;
                    gap    <= '0;
                end
                S_ISSUE: if (rd_en) begin
                    chunk <= last_chunk ? 16'd0 : chunk + 16'd1;
                    gap   <= last_chunk ? '0 : GAP_W'(BEAT_GAP - 1);
                end else begin
                    gap <= gap - GAP_W'(1);
                end
                S_WAIT: if (eng_result_valid) begin
                    res_data <= eng_result;
                    res_row  <= row;
                end
                S_WRITE: if (res_ready) row <= row + 16'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (num_rows == 16'd0) ? S_DONE : S_ISSUE;
            S_ISSUE: if (rd_en && last_chunk) state_nxt = S_WAIT;
            S_WAIT: begin
                if (eng_result_valid)  state_nxt = S_WRITE;
                else if (timeout_hit)  state_nxt = S_DONE;
            end
            S_WRITE: if (res_ready) state_nxt = (row + 16'd1 == rows_q) ? S_DONE : S_ISSUE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // busy covers the accepting cycle itself so it leads done by one cycle on an empty job.
    always_comb begin
        busy      = (state != S_IDLE) || start;
        done      = (state == S_DONE);
        rd_en     = (state == S_ISSUE) && (gap == '0);
        res_valid = (state == S_WRITE);
    end

    for (genvar l = 0; l < NI; l++) begin : g_lane
        localparam int HI = 32 * NI - 1 - 32 * l;
        if (l >= TAIL) begin : g_pad
            assign eng_row_a[HI -: 32] = last_q ? 32'h0 : rd_data_a[HI -: 32];
            assign eng_row_x[HI -: 32] = last_q ? 32'h0 : rd_data_x[HI -: 32];
        end else begin : g_pass
            assign eng_row_a[HI -: 32] = rd_data_a[HI -: 32];
            assign eng_row_x[HI -: 32] = rd_data_x[HI -: 32];
        end
    end

`ifdef DPS_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        err_q;

    assign timeout_hit = (state == S_WAIT) && !eng_result_valid && (wd_cnt == 32'(TIMEOUT - 1));
    assign err         = err_q;

    // Counter sits at zero outside WAIT, so it restarts on every WAIT entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= (state == S_WAIT) ? wd_cnt + 32'd1 : 32'd0;
            if (timeout_hit) err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_dot_product_row_scheduler.sv
// Bench for dot_product_row_scheduler: scenario table, random jobs, and hand-written corner sequences.
module tb_dot_product_row_scheduler;
    localparam int NOE = 10, NI = 8, ADDR_W = 12, BEAT_GAP = 2, TIMEOUT = 16;
    localparam int CHUNKS = (NOE + NI - 1) / NI;
    localparam int TAIL   = NOE - (CHUNKS - 1) * NI;

    logic clk = 0, reset = 1, start = 0;
    logic [15:0] num_rows = 0;
    logic busy, done, rd_en, eng_read_now, eng_valid, res_valid, err;
    logic [ADDR_W-1:0] rd_addr_a, rd_addr_x;
    logic [32*NI-1:0] rd_data_a = '0, rd_data_x = '0, eng_row_a, eng_row_x;
    logic [31:0] eng_no_of_mult, res_data;
    logic eng_result_valid = 0, res_ready = 1;
    logic [31:0] eng_result = 0;
    logic [15:0] res_row;

    dot_product_row_scheduler #(.NOE(NOE), .NI(NI), .ADDR_W(ADDR_W), .BEAT_GAP(BEAT_GAP),
                                .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .num_rows(num_rows), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_x(rd_addr_x), .rd_data_a(rd_data_a),
        .rd_data_x(rd_data_x), .eng_read_now(eng_read_now), .eng_no_of_mult(eng_no_of_mult),
        .eng_valid(eng_valid), .eng_row_a(eng_row_a), .eng_row_x(eng_row_x),
        .eng_result_valid(eng_result_valid), .eng_result(eng_result), .res_valid(res_valid),
        .res_ready(res_ready), .res_row(res_row), .res_data(res_data), .err(err));

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, rd_k = 0, res_k = 0, done_k = 0, beat = 0, last_rd_cyc = 0, err_cyc = 0;
    int eng_lat = 5, eng_cd = 0;
    bit eng_silent = 0, ready_mode = 0, res_seen = 0, err_seen = 0;
    logic [31:0] eng_acc = 0;
    logic [32*NI-1:0] mem_a [64];
    logic [32*NI-1:0] mem_x [4];
    logic [32*NI-1:0] first_a, last_a, last_x;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] lane(input logic [32*NI-1:0] b, input int l);
        return b[32*(NI-1-l) +: 32];
    endfunction

    // Reference: plain sum of the NOE real elements of row r of A and of x.
    function automatic logic [31:0] ref_sum(input int r);
        logic [31:0] s = 0;
        for (int k = 0; k < NOE; k++)
            s += lane(mem_a[r*CHUNKS + k/NI], k % NI) + lane(mem_x[k/NI], k % NI);
        return s;
    endfunction

    task automatic fill_mem(input bit ones);
        for (int i = 0; i < 64; i++)
            for (int l = 0; l < NI; l++) begin
                mem_a[i][32*(NI-1-l) +: 32] = ones ? 32'h3F800000 : $urandom;
                if (i < 4) mem_x[i][32*(NI-1-l) +: 32] = ones ? 32'h3F800000 : $urandom;
            end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr_a];
            rd_data_x <= mem_x[rd_addr_x];
        end
    end

    // Engine model: sums every lane it is handed, answers eng_lat cycles after read_now.
    always @(posedge clk) begin
        eng_result_valid <= 1'b0;
        if (eng_valid) begin
            if (eng_read_now) eng_acc = 0;
            for (int l = 0; l < NI; l++) eng_acc += lane(eng_row_a, l) + lane(eng_row_x, l);
        end
        if (eng_read_now) eng_cd = eng_lat;
        else if (eng_cd > 0) begin
            eng_cd--;
            if (eng_cd == 0 && !eng_silent) begin
                eng_result_valid <= 1'b1;
                eng_result <= eng_acc;
            end
        end
    end

    always @(posedge clk) if (ready_mode) begin
        #1 res_ready = ($urandom % 3) != 0;
    end

    always @(negedge clk) begin
        if (rd_en) begin
            check("rd_addr_a", rd_addr_a, rd_k);
            check("rd_addr_x", rd_addr_x, rd_k % CHUNKS);
            rd_k++;
            last_rd_cyc = cyc;
        end
        if (eng_valid) begin
            if (eng_read_now) beat = 0;
            if (beat == 0) first_a = eng_row_a;
            if (beat == CHUNKS-1) begin last_a = eng_row_a; last_x = eng_row_x; end
            beat++;
        end
        if (res_valid) res_seen = 1;
        if (res_valid && res_ready) begin
            check("res_row", res_row, res_k);
            check("res_data", res_data, ref_sum(res_k));
            res_k++;
        end
        if (done) done_k++;
        if (err && !err_seen) begin err_seen = 1; err_cyc = cyc; end
    end

    task automatic clear_stats();
        rd_k = 0; res_k = 0; done_k = 0; res_seen = 0;
    endtask

    task automatic kick(input int rows);
        @(posedge clk); #1 start = 1; num_rows = 16'(rows);
        @(posedge clk); #1 start = 0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_k == 0; i++) @(posedge clk);
        if (done_k == 0) check("done_timeout", 0, 1);
    endtask

    task automatic run_job(input int rows, input int lat, input bit rr, input bit ones,
                           input int exp_rd, input int exp_res);
        fill_mem(ones);
        clear_stats();
        eng_lat = lat; res_ready = 1; ready_mode = rr;
        kick(rows);
        wait_done(3000);
        ready_mode = 0;
        @(negedge clk);
        res_ready = 1;
        check("rd_pulses", rd_k, exp_rd);
        check("results", res_k, exp_res);
        check("done_pulses", done_k, 1);
        check("busy_after_done", busy, 0);
    endtask

    typedef struct { int rows; int lat; bit rr; int exp_rd; int exp_res; } vec_t;
    vec_t tbl[5];

    initial begin
        tbl[0] = '{3, 5, 0, 6, 3};
        tbl[1] = '{1, 3, 0, 2, 1};
        tbl[2] = '{4, 9, 1, 8, 4};
        tbl[3] = '{2, 12, 1, 4, 2};
        tbl[4] = '{5, 4, 0, 10, 5};
        fill_mem(0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);       check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);     check("rst_eng_valid", eng_valid, 0);
        check("rst_read_now", eng_read_now, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_err", err, 0);         check("rst_addr_a", rd_addr_a, 0);
        check("rst_res_row", res_row, 0); check("rst_res_data", res_data, 0);
        check("no_of_mult", eng_no_of_mult, CHUNKS);
        @(posedge clk); #1 reset = 0;

        // Empty job: done the cycle after busy rises, no reads
        clear_stats();
        @(posedge clk); #1 start = 1; num_rows = 0;
        @(negedge clk);
        check("empty_busy_rise", busy, 1); check("empty_done_early", done, 0);
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        check("empty_done", done, 1); check("empty_busy_hold", busy, 1);
        @(negedge clk);
        check("empty_busy_drop", busy, 0); check("empty_rd", rd_k, 0);

        foreach (tbl[i]) run_job(tbl[i].rows, tbl[i].lat, tbl[i].rr, 0, tbl[i].exp_rd, tbl[i].exp_res);

        // Tail masking with all-ones memory
        run_job(1, 4, 0, 1, CHUNKS, 1);
        for (int l = 0; l < NI; l++) begin
            check($sformatf("first_a_lane%0d", l), lane(first_a, l), 32'h3F800000);
            check($sformatf("last_a_lane%0d", l), lane(last_a, l), (l < TAIL) ? 32'h3F800000 : 32'h0);
            check($sformatf("last_x_lane%0d", l), lane(last_x, l), (l < TAIL) ? 32'h3F800000 : 32'h0);
        end

        // Back-pressure: result held stable, no new reads until accepted
        begin
            int bad, rd_before;
            logic [31:0] d0;
            logic [15:0] r0;
            fill_mem(0); clear_stats();
            eng_lat = 5; res_ready = 0;
            kick(2);
            for (int i = 0; i < 200 && !res_valid; i++) @(negedge clk);
            check("bp_res_valid", res_valid, 1);
            d0 = res_data; r0 = res_row; rd_before = rd_k; bad = 0;
            check("bp_data", d0, ref_sum(0)); check("bp_row", r0, 0);
            repeat (10) begin
                @(negedge clk);
                if (!res_valid || res_data !== d0 || res_row !== r0) bad++;
            end
            check("bp_stable", bad, 0);
            check("bp_no_rd", rd_k, rd_before);
            @(posedge clk); #1 res_ready = 1;
            wait_done(500);
            @(negedge clk);
            check("bp_results", res_k, 2); check("bp_rd", rd_k, 2*CHUNKS);
        end

        // Random jobs against the reference sum
        for (int j = 0; j < 6; j++) begin
            int rows = $urandom_range(1, 6);
            run_job(rows, $urandom_range(3, 10), 1, 0, rows*CHUNKS, rows);
        end

        // Reset in WAIT of row 1; late engine result must be ignored
        begin
            int bad;
            fill_mem(0); clear_stats();
            eng_lat = 12; res_ready = 1;
            kick(3);
            for (int i = 0; i < 200 && rd_k < 2*CHUNKS; i++) @(negedge clk);
            check("mr_reached_row1", rd_k, 2*CHUNKS);
            @(posedge clk); #1 reset = 1;
            @(posedge clk); #1 reset = 0;
            @(negedge clk);
            check("mr_busy", busy, 0);          check("mr_rd_en", rd_en, 0);
            check("mr_eng_valid", eng_valid, 0); check("mr_res_row", res_row, 0);
            check("mr_res_data", res_data, 0);   check("mr_addr_a", rd_addr_a, 0);
            bad = 0;
            repeat (20) begin
                @(negedge clk);
                if (res_valid || busy) bad++;
            end
            check("mr_quiet", bad, 0);
            check("mr_res_data_late", res_data, 0);
            check("mr_done", done_k, 0);
        end

`ifdef DPS_TIMEOUT_EN
        clear_stats(); err_seen = 0; eng_silent = 1;
        kick(2);
        wait_done(300);
        @(negedge clk);
        check("to_err", err, 1);
        check("to_err_delay", err_cyc - last_rd_cyc, TIMEOUT + 1);
        check("to_no_res", res_seen, 0);
        check("to_rd", rd_k, CHUNKS);
        check("to_done", done_k, 1);
        eng_silent = 0;
`else
        check("err_tied", err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
